// File: rtl/dmem_pkg.sv
// Shared types and helpers for the load/store data memory bank.
package dmem_pkg;

    typedef enum logic [1:0] {
        CLEAR    = 2'd0,
        IDLE     = 2'd1,
        RD_PIPE  = 2'd2,
        RSP_HOLD = 2'd3
    } dmem_state_e;

    localparam logic [31:0] DMEM_FILL_DEFAULT = 32'hDEADBEEF;

    function automatic int bytes_of(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Byte-enabled storage with synchronous write and registered read.
// Deliberately has no reset so it can map onto block RAM.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 14
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [bytes_of(DATA_W)-1:0] wmask,
    input  logic [ADDR_W-1:0]           waddr,
    input  logic [DATA_W-1:0]           wdata,
    input  logic                        re,
    input  logic [ADDR_W-1:0]           raddr,
    output logic [DATA_W-1:0]           rdata
);

    localparam int NB = bytes_of(DATA_W);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < NB; b++) begin
                if (wmask[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/dmem_bank_ctrl.sv
// Data memory controller: valid/ready requests, RD_LAT-cycle loads held until taken.
// Optional boot clear of the whole array when DMEM_BOOT_CLEAR_EN is defined.
module dmem_bank_ctrl
    import dmem_pkg::*;
#(
    parameter int          DATA_W = 32,
    parameter int          ADDR_W = 14,
    parameter int          RD_LAT = 1,
    parameter logic [31:0] FILL   = DMEM_FILL_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_we,
    input  logic [ADDR_W-1:0]           req_addr,
    input  logic [DATA_W-1:0]           req_wdata,
    input  logic [bytes_of(DATA_W)-1:0] req_mask,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        busy
);

    localparam int NB = bytes_of(DATA_W);

    dmem_state_e       state;
    logic [1:0]        lat_cnt;
    logic [ADDR_W-1:0] rd_addr;

    logic              arr_we;
    logic [NB-1:0]     arr_wmask;
    logic [ADDR_W-1:0] arr_waddr;
    logic [DATA_W-1:0] arr_wdata;
    logic              arr_re;
    logic [DATA_W-1:0] arr_rdata;

    // Gating with rst keeps a store from landing on an edge while reset is held.
    assign req_ready = (state == IDLE) && !rst;
    assign rsp_valid = (state == RSP_HOLD);
    assign rsp_rdata = rsp_valid ? arr_rdata : '0;
    assign busy      = rst || (state != IDLE);
    assign arr_re    = (state == RD_PIPE) && (lat_cnt == 2'd0);

`ifdef DMEM_BOOT_CLEAR_EN
    logic [ADDR_W:0]   clr_cnt;
    logic [ADDR_W:0]   clr_nxt;
    logic [DATA_W-1:0] fill_w;

    assign clr_nxt = clr_cnt + (ADDR_W+1)'(1);

    always_comb begin
        fill_w = '0;
        for (int i = 0; i < DATA_W; i++) fill_w[i] = FILL[i % 32];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 clr_cnt <= '0;
        else if (state == CLEAR) clr_cnt <= clr_nxt;
    end
`endif

    always_comb begin
        arr_we    = req_valid && req_ready && req_we;
        arr_wmask = req_mask;
        arr_waddr = req_addr;
        arr_wdata = req_wdata;
`ifdef DMEM_BOOT_CLEAR_EN
        if (state == CLEAR) begin
            arr_we    = !rst;
            arr_wmask = '1;
            arr_waddr = clr_cnt[ADDR_W-1:0];
            arr_wdata = fill_w;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
`ifdef DMEM_BOOT_CLEAR_EN
            state <= CLEAR;
`else
            state <= IDLE;
`endif
            lat_cnt <= '0;
            rd_addr <= '0;
        end else begin
            case (state)
`ifdef DMEM_BOOT_CLEAR_EN
                CLEAR: begin
                    // Counter MSB marks that the last word was just written.
                    if (clr_nxt[ADDR_W]) state <= IDLE;
                end
`endif
                IDLE: begin
                    if (req_valid && !req_we) begin
                        rd_addr <= req_addr;
                        lat_cnt <= 2'(RD_LAT - 1);
                        state   <= RD_PIPE;
                    end
                end
                RD_PIPE: begin
                    if (lat_cnt == 2'd0) state <= RSP_HOLD;
                    else                 lat_cnt <= lat_cnt - 2'd1;
                end
                RSP_HOLD: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .wmask (arr_wmask),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .re    (arr_re),
        .raddr (rd_addr),
        .rdata (arr_rdata)
    );

endmodule
